// File: rtl/line_memory_responder_if.sv
// Line-granular memory bus between the data cache (master) and the memory responder (slave).
// The shared 256-bit data line is resolved here from each side's registered drive enable.
interface line_memory_responder_if;
  logic [31:0]  address;
  logic         read;
  logic         write;
  logic         ready;
  logic         done;
  logic [255:0] wr_data;
  logic         wr_drive;
  logic [255:0] rsp_data;
  logic         rsp_drive;
  wire  [255:0] data;

  assign data = wr_drive  ? wr_data  : 'z;
  assign data = rsp_drive ? rsp_data : 'z;

  modport master (
    output address, read, write, wr_data, wr_drive,
    input  ready, done, data
  );

  modport slave (
    input  address, read, write, data,
    output ready, done, rsp_data, rsp_drive
  );
endinterface

// File: rtl/line_memory_responder.sv
// Fixed-latency line memory: one 32-byte read or write in flight, answered by a one-cycle
// ready/done pulse, then waits for the initiator to drop its strobe before accepting again.
module line_memory_responder #(
  parameter int unsigned DEPTH_LINES = 1024,
  parameter int unsigned LATENCY     = 4
) (
  input logic                    clock,
  input logic                    reset,
  line_memory_responder_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND, RELEASE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic [255:0]     wdata_q;
  logic             op_write_q;
  logic [CNT_W-1:0] count;
  logic [255:0]     rdata_q;
  logic             ready_q;
  logic             done_q;
  logic             drive_q;
  logic [255:0]     mem [DEPTH_LINES];

  logic [IDX_W-1:0] cur_idx;
  logic [255:0]     cur_wdata;
  logic             cur_write;
  logic             strobe_held;
  logic             enter_respond;

  // In IDLE the request is taken straight from the bus so LATENCY=1 can respond at acceptance.
  always_comb begin
    strobe_held = op_write_q ? bus.write : bus.read;
    if (state == IDLE) begin
      cur_idx       = bus.address[5 +: IDX_W];
      cur_wdata     = bus.data;
      cur_write     = bus.write;
      enter_respond = (LATENCY == 1) && (bus.read || bus.write);
    end else begin
      cur_idx       = idx_q;
      cur_wdata     = wdata_q;
      cur_write     = op_write_q;
      enter_respond = (state == BUSY) && strobe_held && (count == '0);
    end
  end

  // Storage is deliberately not reset; only a live (non-reset) commit may update it.
  always_ff @(posedge clock) begin
    if (reset && enter_respond && cur_write)
      mem[cur_idx] <= cur_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx_q      <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      count      <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      drive_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      drive_q <= 1'b0;
      if (enter_respond) begin
        state   <= RESPOND;
        ready_q <= !cur_write;
        done_q  <= cur_write;
        drive_q <= !cur_write;
        if (!cur_write)
          rdata_q <= mem[cur_idx];
      end
      case (state)
        IDLE: begin
          if (bus.read || bus.write) begin
            idx_q      <= cur_idx;
            wdata_q    <= bus.data;
            op_write_q <= bus.write;
            count      <= CNT_INIT;
            if (LATENCY != 1)
              state <= BUSY;
          end
        end
        BUSY: begin
          if (!strobe_held)
            state <= IDLE;
          else if (count != '0)
            count <= count - 1'b1;
        end
        RESPOND: state <= RELEASE;
        RELEASE: begin
          if (!bus.read && !bus.write)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.rsp_data  = rdata_q;
  assign bus.rsp_drive = drive_q;
endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder (DEPTH_LINES=16, LATENCY=4) with hand-computed expectations.
module tb_line_memory_responder;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  line_memory_responder_if bus ();

  line_memory_responder #(.DEPTH_LINES(16), .LATENCY(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  int           lat;
  int           n_ready;
  int           n_done;
  int           z_bad;
  logic [255:0] rdata;

  // Drives one request from a negedge, waits (bounded) for the response, then drops the
  // strobe and lets the responder pass through RESPOND and RELEASE back to IDLE.
  task automatic xact(input logic [31:0] addr, input logic rd, input logic wr,
                      input logic [255:0] wdata);
    int   edges;
    logic seen;
    n_ready = 0; n_done = 0; z_bad = 0; lat = -1; rdata = '0; seen = 1'b0; edges = 0;
    bus.address  = addr;
    bus.read     = rd;
    bus.write    = wr;
    bus.wr_data  = wdata;
    bus.wr_drive = wr;
    while (!seen && edges < 40) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      bus.wr_data = ~wdata;
      if (bus.ready || bus.done) begin
        seen    = 1'b1;
        lat     = edges - 1;
        rdata   = bus.data;
        n_ready += int'(bus.ready);
        n_done  += int'(bus.done);
        if (bus.ready && !bus.rsp_drive) z_bad++;
      end else if (bus.rsp_drive) begin
        z_bad++;
      end
    end
    bus.read     = 1'b0;
    bus.write    = 1'b0;
    bus.wr_drive = 1'b0;
    @(negedge clock);
    n_ready += int'(bus.ready);
    n_done  += int'(bus.done);
    if (bus.rsp_drive) z_bad++;
    @(negedge clock);
  endtask

  logic [255:0] pa, p1, p2, p3, p4, p5, q80, rc0;

  initial begin
    for (int i = 0; i < 8; i++) pa[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
    p1  = {8{32'h1111_2222}};
    p2  = {8{32'h3333_4444}};
    p3  = {8{32'hDEAD_BEEF}};
    p4  = {8{32'hCAFE_F00D}};
    p5  = {8{32'h5555_AAAA}};
    q80 = {8{32'h0BAD_0080}};
    rc0 = {8{32'h600D_00C0}};

    reset = 1'b0;
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.wr_data = '0; bus.wr_drive = 1'b0;
    #1;
    check("reset_ready",  256'(bus.ready), '0);
    check("reset_done",   256'(bus.done), '0);
    check("reset_data_z", 256'(bus.rsp_drive), '0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    xact(32'h40, 1'b0, 1'b1, pa);
    check("wr_latency",     256'(lat), 256'(4));
    check("wr_done_pulses", 256'(n_done), 256'(1));
    check("wr_no_ready",    256'(n_ready), '0);
    xact(32'h40, 1'b1, 1'b0, '0);
    check("rd_latency",      256'(lat), 256'(4));
    check("rd_data",         rdata, pa);
    check("rd_ready_pulses", 256'(n_ready), 256'(1));
    check("rd_data_z_else",  256'(z_bad), '0);
    check("rd_no_done",      256'(n_done), '0);

    xact(32'h5C, 1'b1, 1'b0, '0);
    check("offset_data", rdata, pa);

    xact(32'h000, 1'b0, 1'b1, p1);
    xact(32'h200, 1'b1, 1'b0, '0);
    check("wrap_p1", rdata, p1);
    xact(32'h220, 1'b0, 1'b1, p2);
    xact(32'h020, 1'b1, 1'b0, '0);
    check("wrap_p2", rdata, p2);
    xact(32'h000, 1'b1, 1'b0, '0);
    check("wrap_p1_kept", rdata, p1);

    // Read strobe held long after its response: only one ready pulse.
    bus.address = 32'h40;
    bus.read    = 1'b1;
    n_ready = 0;
    repeat (30) begin
      @(negedge clock);
      n_ready += int'(bus.ready);
    end
    check("held_ready_pulses", 256'(n_ready), 256'(1));
    bus.read = 1'b0;
    @(negedge clock);
    xact(32'h40, 1'b1, 1'b0, '0);
    check("reaccept_latency", 256'(lat), 256'(4));
    check("reaccept_data",    rdata, pa);

    xact(32'h60, 1'b1, 1'b1, p5);
    check("both_done",    256'(n_done), 256'(1));
    check("both_ready",   256'(n_ready), '0);
    check("both_latency", 256'(lat), 256'(4));
    xact(32'h60, 1'b1, 1'b0, '0);
    check("both_stored", rdata, p5);

    // Abort: write strobe dropped after two BUSY edges.
    xact(32'h80, 1'b0, 1'b1, q80);
    bus.address = 32'h80; bus.write = 1'b1; bus.wr_data = p3; bus.wr_drive = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    bus.write = 1'b0; bus.wr_drive = 1'b0;
    n_done = 0;
    repeat (10) begin
      @(negedge clock);
      n_done += int'(bus.done);
    end
    check("abort_no_done", 256'(n_done), '0);
    xact(32'h80, 1'b1, 1'b0, '0);
    check("abort_old_data", rdata, q80);

    // Asynchronous reset in the middle of a write's BUSY phase.
    xact(32'hC0, 1'b0, 1'b1, rc0);
    bus.address = 32'hC0; bus.write = 1'b1; bus.wr_data = p4; bus.wr_drive = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_busy_done",   256'(bus.done), '0);
    check("rst_busy_ready",  256'(bus.ready), '0);
    check("rst_busy_data_z", 256'(bus.rsp_drive), '0);
    bus.write = 1'b0; bus.wr_drive = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    xact(32'hC0, 1'b1, 1'b0, '0);
    check("rst_old_data", rdata, rc0);

    // Asynchronous reset while ready is high must clear it without a clock edge.
    bus.address = 32'hC0; bus.read = 1'b1;
    n_ready = 0;
    for (int i = 0; i < 20 && n_ready == 0; i++) begin
      @(negedge clock);
      n_ready += int'(bus.ready);
    end
    check("resp_ready_seen", 256'(n_ready), 256'(1));
    #1 reset = 1'b0;
    #1;
    check("rst_resp_ready",  256'(bus.ready), '0);
    check("rst_resp_data_z", 256'(bus.rsp_drive), '0);
    bus.read = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    xact(32'h40, 1'b1, 1'b0, '0);
    check("storage_survives_reset", rdata, pa);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d checks", n_pass, n_checks);
    $fatal(1);
  end
endmodule
